// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated channel multiplexer.
package arb_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Grant generator: rotating-priority or fixed-priority search over the
// request vector. Produces a one-hot grant and its index.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SELW     = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SELW-1:0]     ptr_i,
  input  logic                mode_fixed_i,
  output logic [CHANNELS-1:0] gnt_o,
  output logic [SELW-1:0]     gnt_idx_o,
  output logic                gnt_any_o
);

  logic [SELW-1:0]       start;
  logic [2*CHANNELS-1:0] rot;
  int                    sum;

  // Rotate requests so the search always begins at bit 0, take the first
  // set bit, then map the offset back to an absolute channel index.
  always_comb begin
    start     = mode_fixed_i ? '0 : ptr_i;
    rot       = {req_i, req_i} >> start;
    gnt_any_o = 1'b0;
    sum       = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!gnt_any_o && rot[k]) begin
        gnt_any_o = 1'b1;
        sum       = int'(start) + k;
      end
    end
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    gnt_idx_o = SELW'(sum);
    for (int j = 0; j < CHANNELS; j++) begin
      gnt_o[j] = gnt_any_o && (gnt_idx_o == SELW'(j));
    end
  end

endmodule

// File: rtl/arb_mux.sv
// CHANNELS-to-1 arbitrated multiplexer with a single registered output stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds valid/data until that edge, and ready may depend
// combinationally on valid (in_ready is a function of in_valid and the output
// register state), never the other way round.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_RR,
  localparam int SELW     = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);

  localparam logic MODE_IS_FIXED = (MODE == MODE_FIXED);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_sel_q,   out_sel_d;
  logic [SELW-1:0]     ptr_q,       ptr_d;

  logic                load_en;
  logic                grant_en;
  logic [CHANNELS-1:0] gnt;
  logic [SELW-1:0]     gnt_idx;
  logic                gnt_any;
  logic [SELW-1:0]     ptr_next;
  logic [WIDTH-1:0]    ch_data [CHANNELS];

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_arb (
    .req_i        (in_valid),
    .ptr_i        (ptr_q),
    .mode_fixed_i (MODE_IS_FIXED),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .gnt_any_o    (gnt_any)
  );

  // The output register can take a new word when empty or being drained.
  assign load_en  = ~out_valid_q | out_ready;
  // No grant is ever issued while reset is asserted.
  assign grant_en = reset_n & load_en & gnt_any;
  assign in_ready = grant_en ? gnt : '0;
  assign ptr_next = (gnt_idx == SELW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;

  // Unpack the flat input bus into per-channel words for indexed selection.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (gnt_any) begin
        out_valid_d = 1'b1;
        out_data_d  = ch_data[gnt_idx];
        out_sel_d   = gnt_idx;
        if (!MODE_IS_FIXED) ptr_d = ptr_next;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one round-robin and one fixed-priority instance share
// the same stimulus; a cycle-level reference model predicts grants and pushes
// expected words, and a monitor compares every presented output word.
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic             out_ready;

  logic [1:0][N-1:0] in_ready_w;
  logic [1:0]        out_valid_w;
  logic [1:0][W-1:0] out_data_w;
  logic [1:0][1:0]   out_sel_w;

  int checks = 0;
  int errors = 0;

  // {sel, data} expected per instance: 0 = round-robin, 1 = fixed
  logic [W+1:0] exp_q0[$];
  logic [W+1:0] exp_q1[$];

  int ptr_m [2];
  bit occ_m [2];
  int exp_g [2];

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(MODE_RR)) dut_rr (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]),
    .out_data(out_data_w[0]), .out_sel(out_sel_w[0]), .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(MODE_FIXED)) dut_fx (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]),
    .out_data(out_data_w[1]), .out_sel(out_sel_w[1]), .out_ready(out_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int m);
    return (m == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [W+1:0] q_front(input int m);
    return (m == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  // ---------------- reference model ----------------
  initial begin
    for (int m = 0; m < 2; m++) begin
      ptr_m[m] = 0; occ_m[m] = 0; exp_g[m] = -1;
    end
  end

  // Predict this cycle's grant from the model state and the current inputs.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int start;
      int c;
      exp_g[m] = -1;
      if (reset_n && (!occ_m[m] || out_ready) && in_valid != 0) begin
        start = (m == 0) ? ptr_m[m] : 0;
        for (int k = 0; k < N; k++) begin
          c = (start + k) % N;
          if (exp_g[m] < 0 && in_valid[c]) exp_g[m] = c;
        end
      end
      chk(m == 0 ? "rr_in_ready" : "fx_in_ready", int'(in_ready_w[m]),
          (exp_g[m] >= 0) ? (1 << exp_g[m]) : 0);
      chk(m == 0 ? "rr_out_valid" : "fx_out_valid", int'(out_valid_w[m]), int'(occ_m[m]));
    end
  end

  // Advance the model at the edge the DUT updates on.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) begin
        occ_m[m] = 0;
        ptr_m[m] = 0;
        if (m == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (!occ_m[m] || out_ready) begin
        if (exp_g[m] >= 0) begin
          logic [W+1:0] e;
          e = {2'(exp_g[m]), in_data[exp_g[m]*W +: W]};
          occ_m[m] = 1;
          if (m == 0) begin
            exp_q0.push_back(e);
            ptr_m[m] = (exp_g[m] + 1) % N;
          end else begin
            exp_q1.push_back(e);
          end
        end else begin
          occ_m[m] = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (out_valid_w[m]) begin
        if (q_size(m) == 0) begin
          chk(m == 0 ? "rr_unexpected_word" : "fx_unexpected_word", 1, 0);
        end else begin
          chk(m == 0 ? "rr_out_sel" : "fx_out_sel", int'(out_sel_w[m]), int'(q_front(m)[W+1:W]));
          chk(m == 0 ? "rr_out_data" : "fx_out_data", int'(out_data_w[m]), int'(q_front(m)[W-1:0]));
          if (out_ready) begin
            if (m == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_inc_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
  endtask

  int c1;
  int c3;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    in_data   = $urandom;
    out_ready = 1'b1;
    step(2);
    // Reset holds everything quiet even with all channels requesting.
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("reset_in_ready", int'(in_ready_w[m]), 0);
      chk("reset_out_valid", int'(out_valid_w[m]), 0);
      chk("reset_out_data", int'(out_data_w[m]), 0);
      chk("reset_out_sel", int'(out_sel_w[m]), 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Round-robin rotation at full throughput.
    set_inc_data();
    in_valid = 4'b1111; out_ready = 1'b1;
    step(6);

    // Backpressure for three cycles, then release.
    out_ready = 1'b0;
    step(3);
    out_ready = 1'b1;
    step(3);

    // Wrap-around: drive ptr to 3 via channel 2, then search wraps to 2.
    reset_n = 1'b0; step(1); reset_n = 1'b1;
    in_valid = 4'b0100;
    step(4);

    // Fixed priority with channels 1 and 3 held.
    in_valid = 4'b1010;
    c1 = 0; c3 = 0;
    repeat (6) begin
      @(negedge clk);
      if (in_ready_w[1][1]) c1++;
      if (in_ready_w[1][3]) c3++;
      @(posedge clk); #1;
    end
    chk("fx_ch1_grants", c1, 6);
    chk("fx_ch3_grants", c3, 0);

    // Reset pulse while a word is held under backpressure.
    in_valid = 4'b1111; out_ready = 1'b0;
    step(2);
    reset_n = 1'b0; step(1);
    reset_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_rr_grant", int'(in_ready_w[0]), 1);
    @(posedge clk); #1;
    step(3);

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 500; t++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      reset_n   = ($urandom_range(0, 63) != 0);
      step(1);
    end
    reset_n = 1'b1; in_valid = '0; out_ready = 1'b1;
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
